// File: rtl/ring_meter_pkg.sv
// Shared definitions for the ring oscillator frequency meter: FSM state type
// and default widths.
package ring_meter_pkg;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_GATE_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GATE = 1'b1
  } meter_state_e;

endpackage

// File: rtl/osc_sync_rise.sv
// Brings the asynchronous ring oscillator output into the clk domain and turns
// each rising edge into a single-cycle rise pulse.
module osc_sync_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic osc_in,
  output logic rise
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = osc_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/ring_freq_meter.sv
// Gated frequency meter: counts synchronised oscillator rising edges over a
// window of 2^gate_sel clk cycles and reports a saturating result.
module ring_freq_meter
  import ring_meter_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int GATE_W = DEF_GATE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              osc_in,
  input  logic              start,
  input  logic              cont,
  input  logic [GATE_W-1:0] gate_sel,
  output logic [CNT_W-1:0]  count,
  output logic              valid,
  output logic              busy,
  output logic              overflow
);

  localparam int WIN_W = (1 << GATE_W) - 1;

  // Handshake: valid is a one-cycle strobe with no ready; count/overflow are
  // stable from the valid cycle until the next strobe.
  meter_state_e     state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic             rise;
  logic [WIN_W-1:0] win_load;
  logic [CNT_W-1:0] acc_nx;
  logic             sat_nx;

  osc_sync_rise u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .osc_in (osc_in),
    .rise   (rise)
  );

  // N-1 for N = 2^gate_sel is simply gate_sel low-order ones.
  always_comb begin
    win_load = '0;
    for (int i = 0; i < WIN_W; i++) begin
      win_load[i] = (i < int'(gate_sel));
    end
  end

  // Saturating accumulate; sat tracks that the true total passed all-ones.
  always_comb begin
    acc_nx = acc_q;
    sat_nx = sat_q;
    if (rise) begin
      if (&acc_q) begin
        sat_nx = 1'b1;
      end else begin
        acc_nx = acc_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start || cont) begin
          state_d = ST_GATE;
          win_d   = win_load;
          acc_d   = '0;
          sat_d   = 1'b0;
        end
      end
      ST_GATE: begin
        if (win_q == '0) begin
          count_d = acc_nx;
          ovf_d   = sat_nx;
          valid_d = 1'b1;
          if (cont) begin
            // Fresh window starts on this very edge so no edge is lost.
            win_d = win_load;
            acc_d = '0;
            sat_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          win_d = win_q - WIN_W'(1);
          acc_d = acc_nx;
          sat_d = sat_nx;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign count    = count_q;
  assign valid    = valid_q;
  assign busy     = (state_q == ST_GATE);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_ring_freq_meter.sv
// Bench for ring_freq_meter: a 16-bit and a 4-bit instance share stimulus and
// are scored against an edge-counting window model.
module tb_ring_freq_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        osc_in = 1'b0;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic [3:0]  gate_sel = 4'd0;
  logic [15:0] count16;
  logic        valid16, busy16, ovf16;
  logic [3:0]  count4;
  logic        valid4, busy4, ovf4;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  // ---------------- clock / DUTs ----------------
  always #5 clk = ~clk;

  ring_freq_meter #(.CNT_W(16), .GATE_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .start(start), .cont(cont),
    .gate_sel(gate_sel), .count(count16), .valid(valid16), .busy(busy16),
    .overflow(ovf16)
  );

  ring_freq_meter #(.CNT_W(4), .GATE_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .start(start), .cont(cont),
    .gate_sel(gate_sel), .count(count4), .valid(valid4), .busy(busy4),
    .overflow(ovf4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- oscillator source ----------------
  int   osc_mode = 0;   // 0 stuck, 1 fixed half-period, 2 random half-period
  logic osc_stuck = 1'b0;
  int   osc_half = 4;
  int   osc_rmax = 3;
  int   ph = 0;

  always @(negedge clk) begin
    if (osc_mode == 0) begin
      osc_in = osc_stuck;
    end else if (ph <= 1) begin
      osc_in = ~osc_in;
      ph = (osc_mode == 1) ? osc_half : int'($urandom_range(osc_rmax, 1));
    end else begin
      ph--;
    end
  end

  // ---------------- reference model ----------------
  // A window opened at edge S with length N counts every 0->1 step of the
  // oscillator as sampled at edges S-2 .. S+N-2; the result appears at S+N.
  logic        osc_hist [0:99999];
  logic [47:0] exp_q16[$];
  logic [47:0] exp_q4[$];
  bit          m_busy = 1'b0;
  int          m_start = 0;
  int          m_end = 0;

  initial for (int i = 0; i < 100000; i++) osc_hist[i] = 1'b0;

  always @(posedge clk) begin
    int edges;
    cyc++;
    if (cyc < 100000) osc_hist[cyc] = rst_n ? osc_in : 1'b0;
    if (!rst_n) begin
      m_busy = 1'b0;
      exp_q16.delete();
      exp_q4.delete();
    end else if (m_busy && cyc == m_end) begin
      edges = 0;
      for (int j = m_start - 1; j <= m_end - 2; j++)
        if (j >= 1 && osc_hist[j] && !osc_hist[j-1]) edges++;
      exp_q16.push_back({32'(cyc), 16'(edges)});
      exp_q4.push_back({32'(cyc), 16'(edges)});
      if (cont) begin
        m_start = cyc;
        m_end   = cyc + (1 << gate_sel);
      end else begin
        m_busy = 1'b0;
      end
    end else if (!m_busy && (start || cont)) begin
      m_busy  = 1'b1;
      m_start = cyc;
      m_end   = cyc + (1 << gate_sel);
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [15:0] last16_cnt = '0;
  logic        last16_ovf = 1'b0;
  logic [3:0]  last4_cnt = '0;
  logic        last4_ovf = 1'b0;

  always @(negedge clk) begin
    logic        ev16, ev4;
    logic [47:0] e;
    if (mon_en) begin
      ev16 = (exp_q16.size() > 0) && (exp_q16[0][47:16] == 32'(cyc));
      ev4  = (exp_q4.size() > 0) && (exp_q4[0][47:16] == 32'(cyc));
      if (ev16) begin
        e = exp_q16.pop_front();
        last16_cnt = e[15:0];
        last16_ovf = 1'b0;
      end
      if (ev4) begin
        e = exp_q4.pop_front();
        last4_cnt = (e[15:0] > 16'd15) ? 4'd15 : e[3:0];
        last4_ovf = (e[15:0] > 16'd15);
      end
      if (!rst_n) begin
        last16_cnt = '0; last16_ovf = 1'b0;
        last4_cnt  = '0; last4_ovf  = 1'b0;
      end
      chk("valid16", 32'(valid16), 32'(ev16));
      chk("busy16",  32'(busy16),  32'(m_busy));
      chk("count16", 32'(count16), 32'(last16_cnt));
      chk("ovf16",   32'(ovf16),   32'(last16_ovf));
      chk("valid4",  32'(valid4),  32'(ev4));
      chk("busy4",   32'(busy4),   32'(m_busy));
      chk("count4",  32'(count4),  32'(last4_cnt));
      chk("ovf4",    32'(ovf4),    32'(last4_ovf));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy16 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle timeout cyc=%0d busy=%0b exp=0", cyc, busy16);
    end
  endtask

  task automatic set_period(input int p);
    osc_mode = 1;
    osc_half = p / 2;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_count16"}, 32'(count16), 32'd0);
    chk({nm, "_valid16"}, 32'(valid16), 32'd0);
    chk({nm, "_busy16"},  32'(busy16),  32'd0);
    chk({nm, "_ovf16"},   32'(ovf16),   32'd0);
    chk({nm, "_count4"},  32'(count4),  32'd0);
    chk({nm, "_busy4"},   32'(busy4),   32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 rst_n = 1'b0;
    #1 check_zero("reset");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;

    // Period 8 over 64 cycles: 8 edges.
    set_period(8);
    repeat (10) @(negedge clk);
    gate_sel = 4'd6;
    pulse_start();
    wait_idle();
    chk("t1_count16", 32'(count16), 32'd8);
    chk("t1_ovf16",   32'(ovf16),   32'd0);

    // Period 4 over 128 cycles: 32 edges saturate the 4-bit result.
    set_period(4);
    gate_sel = 4'd7;
    pulse_start();
    wait_idle();
    chk("t2_count4",  32'(count4),  32'd15);
    chk("t2_ovf4",    32'(ovf4),    32'd1);
    chk("t2_count16", 32'(count16), 32'd32);

    // Stuck oscillator, both levels.
    for (int lvl = 0; lvl < 2; lvl++) begin
      osc_mode = 0;
      osc_stuck = lvl[0];
      repeat (8) @(negedge clk);
      gate_sel = 4'd3;
      pulse_start();
      wait_idle();
      chk("t3_count16", 32'(count16), 32'd0);
      chk("t3_ovf4",    32'(ovf4),    32'd0);
    end

    // Re-triggering start and changing gate_sel mid-window.
    set_period(8);
    repeat (10) @(negedge clk);
    gate_sel = 4'd6;
    pulse_start();
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0; gate_sel = 4'd2;
    repeat (14) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_idle();
    chk("t4_count16", 32'(count16), 32'd8);

    // Continuous mode, 16-cycle windows at period 8.
    gate_sel = 4'd4;
    @(negedge clk); cont = 1'b1;
    repeat (16 * 6) @(negedge clk);
    cont = 1'b0;
    wait_idle();
    chk("t5_count16", 32'(count16), 32'd2);

    // Reset in the middle of a window, then a clean measurement.
    gate_sel = 4'd6;
    pulse_start();
    repeat (28) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    pulse_start();
    wait_idle();
    chk("t6_count16", 32'(count16), 32'd8);

    // Randomised traffic.
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(3, 0))
        0: begin osc_mode = 0; osc_stuck = 1'($urandom_range(1, 0)); end
        1: begin osc_mode = 1; osc_half = $urandom_range(10, 1); end
        default: begin osc_mode = 2; osc_rmax = $urandom_range(6, 1); end
      endcase
      gate_sel = 4'($urandom_range(8, 0));
      if ($urandom_range(3, 0) == 0) begin
        @(negedge clk); cont = 1'b1;
        repeat ($urandom_range(600, 20)) begin
          @(negedge clk);
          if ($urandom_range(7, 0) == 0) gate_sel = 4'($urandom_range(8, 0));
        end
        cont = 1'b0;
      end else begin
        pulse_start();
        repeat ($urandom_range(40, 0)) begin
          @(negedge clk);
          start = 1'($urandom_range(1, 0));
          if ($urandom_range(5, 0) == 0) gate_sel = 4'($urandom_range(8, 0));
        end
        start = 1'b0;
      end
      wait_idle();
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ring_freq_meter.md
# ring_freq_meter

Gated frequency meter that sits directly downstream of the tapped ring oscillator. It takes the free-running, asynchronous oscillator output and synchronises it into the `clk` domain. It then counts its rising edges over a programmable window of 2^`gate_sel` clock cycles and presents a saturating count with a one-cycle `valid` strobe. The result gives a direct tap-versus-frequency readout without off-chip instruments.

## Interface
Parameters:
- `CNT_W`, 16: width of the edge-count result.
- `GATE_W`, 4: width of `gate_sel`; the maximum window is 2^(2^GATE_W − 1) cycles.

Ports:
- `clk`  in  1: system clock; the only clock.
- `rst_n`  in  1: reset, asynchronous assert, active-low; clears all state.
- `osc_in`  in  1: ring oscillator output, asynchronous to `clk`. Measurable only while its frequency is below `clk`/2.
- `start`  in  1: level-sampled request to begin one measurement.
- `cont`  in  1: continuous mode; re-arms automatically after every window.
- `gate_sel`  in  GATE_W: window length exponent, N = 2^`gate_sel` cycles. Sampled only when a window starts.
- `count`  out  CNT_W: last completed measurement result.
- `valid`  out  1: one-cycle strobe marking a new `count`.
- `busy`  out  1: a window is in progress.
- `overflow`  out  1: the last result saturated.

## Operation
- Synchroniser chain: two flops then one history flop, all free-running in every state. `rise = s2 & ~s3`.
- FSM has two states, IDLE and GATE.
  - IDLE → GATE: when `start`=1 or `cont`=1. Loads the window counter with N−1, clears the edge accumulator, latches `gate_sel`.
  - GATE: each cycle, the accumulator increments when `rise`=1 and holds at all-ones once saturated. The window counter decrements.
  - GATE → IDLE: on the cycle the window counter is 0, which is the last counted cycle.
  - On that transition: `count` ← final accumulator value including that cycle's `rise`; `overflow` ← 1 if the true edge total exceeded 2^CNT_W − 1; `valid` pulses.
  - Continuous mode: if `cont`=1 at that transition, the FSM goes directly to GATE with a fresh window instead. There are no dead cycles and no edges are lost between windows.
- `start` while `busy`=1 is ignored; there is no queueing.
- `count` and `overflow` hold their values until the next window completes.
- `gate_sel` changes during GATE have no effect on the current window.
- Reset mid-window aborts the measurement. All outputs go to 0 and the FSM returns to IDLE. No `valid` is produced.

## Timing
- Reset values: `count`=0, `valid`=0, `busy`=0, `overflow`=0, all synchroniser flops 0.
- `start` high at edge E0, with the FSM in IDLE:
  - `busy`=1 from E0+1.
  - `rise` is sampled at edges E1..EN, exactly N samples.
  - `count`, `overflow` and `valid`=1 update at edge EN+1, and `busy`=0 at the same edge.
  - `valid` falls at EN+2.
- `start` held high at EN+1: a new window begins at that edge, so back-to-back measurement is possible with one IDLE cycle.
- `cont`=1: `valid` strobes every N cycles and `busy` stays 1 throughout.
- Synchroniser latency is 2–3 cycles. Edges are attributed to windows with that fixed offset.
- An edge arriving within the last 2 cycles of a window counts toward the next window in continuous mode, or is dropped otherwise.

## Structure
- Shared package `ring_meter_pkg`: FSM state typedef (IDLE, GATE) and default `CNT_W`/`GATE_W` constants.
- Sub-module `osc_sync_rise`: the 2-flop synchroniser plus history flop, with asynchronous active-low reset. Its output is the single-cycle `rise` pulse.
- Top level contains the FSM, the window down-counter (2^GATE_W − 1 bits wide) and the saturating accumulator.

## Test plan
- `osc_in` period exactly 8 `clk`, phase-locked; `gate_sel`=6; pulse `start` → after 65 cycles, `valid`=1 for one cycle, `count`=8, `overflow`=0.
- `CNT_W`=4 override; `osc_in` period 4 `clk`; `gate_sel`=7 → `count`=15, `overflow`=1.
- `osc_in` stuck at 0 or 1; `gate_sel`=3 → `valid` at start+9, `count`=0, `overflow`=0.
- Pulse `start` again at cycles 5 and 20 of a 64-cycle window → exactly one `valid`, at start+65. `gate_sel` changed mid-window has no effect.
- `cont`=1, `gate_sel`=4, `osc_in` period 8 → `valid` every 16 cycles, `count`=2 each time, `busy` continuously 1.
- Assert `rst_n`=0 at cycle 30 of a 64-cycle window → outputs immediately 0, no `valid`. A subsequent `start` gives a correct full measurement.
